sobel_stream: RTL and testbench

Parametrised streaming Sobel edge filter, successor to the fixed 640x480 4-bit horizontal-gradient filter. It accepts one raster-order frame of pixels through a valid/ready handshake and keeps two line buffers internally. Each centre pixel gets a 3x3 window and a selectable gradient mode (Gx, Gy, |Gx|+|Gy|, or saturated raw magnitude). Output pixels go out with their frame address for direct write into the frame-buffer BRAM. Border pixels are forced to zero, and a flush phase at the end of the frame drains the window so every address 0..N-1 is written exactly once.

---
 rtl/sobel_stream.sv | 173 +++++++++++++++++
 tb/tb_sobel_stream.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel edge filter: raster-order pixels in, one filtered pixel
// per accepted input out with its frame address, then a short flush of border zeros.
module sobel_stream #(
   parameter int IMG_W  = 640,
   parameter int IMG_H  = 480,
   parameter int PIX_W  = 4,
   parameter int ADDR_W = $clog2(IMG_W*IMG_H)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [1:0]        mode,
   input  logic [PIX_W+3:0]  thresh,
   input  logic [PIX_W-1:0]  in_pixel,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [PIX_W-1:0]  out_pixel,
   output logic [ADDR_W-1:0] out_addr,
   output logic              out_valid,
   output logic              busy,
   output logic              done
);

   localparam int N  = IMG_W*IMG_H;
   localparam int SW = PIX_W+4;
   localparam int XW = $clog2(IMG_W);
   localparam int YW = $clog2(IMG_H+1);

   typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

   state_t              state;
   logic [1:0]          mode_q;
   logic [SW-1:0]       thresh_q;
   logic                last_q;
   logic [XW-1:0]       in_x, oc_x;
   logic [YW-1:0]       in_y, oc_y;
   logic [ADDR_W-1:0]   oc_addr;

   logic [PIX_W-1:0]    lb0 [IMG_W];
   logic [PIX_W-1:0]    lb1 [IMG_W];
   logic [PIX_W-1:0]    win [3][3];
   logic [PIX_W-1:0]    nw  [3][3];

   logic                acc, emit, border, last_in;
   logic signed [SW-1:0] gx, gy;
   logic [SW-1:0]       ax, ay;
   logic [SW:0]         mag;
   logic [PIX_W-1:0]    res;

   function automatic logic signed [SW-1:0] ext(input logic [PIX_W-1:0] v);
      return $signed({4'b0000, v});
   endfunction

   assign in_ready = (state == RUN);
   assign acc      = in_valid && in_ready && !start;
   // Inputs 0..IMG_W only prime the line buffers; later ones each complete a window.
   assign emit     = (in_y != '0 && in_x != '0) || (in_y > YW'(1));
   assign last_in  = (in_x == XW'(IMG_W-1)) && (in_y == YW'(IMG_H-1));
   assign border   = (oc_x == '0) || (oc_x == XW'(IMG_W-1)) ||
                     (oc_y == '0) || (oc_y == YW'(IMG_H-1));

   // Window as it will look after shifting in the current column (top, mid, new).
   always_comb begin
      for (int r = 0; r < 3; r++) begin
         nw[r][0] = win[r][1];
         nw[r][1] = win[r][2];
      end
      nw[0][2] = lb0[in_x];
      nw[1][2] = lb1[in_x];
      nw[2][2] = in_pixel;
   end

   always_comb begin
      gx  = (ext(nw[0][2]) + (ext(nw[1][2]) <<< 1) + ext(nw[2][2]))
          - (ext(nw[0][0]) + (ext(nw[1][0]) <<< 1) + ext(nw[2][0]));
      gy  = (ext(nw[2][0]) + (ext(nw[2][1]) <<< 1) + ext(nw[2][2]))
          - (ext(nw[0][0]) + (ext(nw[0][1]) <<< 1) + ext(nw[0][2]));
      ax  = gx[SW-1] ? $unsigned(-gx) : $unsigned(gx);
      ay  = gy[SW-1] ? $unsigned(-gy) : $unsigned(gy);
      mag = {1'b0, ax} + {1'b0, ay};
      res = '0;
      case (mode_q)
         2'd0: res = (!gx[SW-1] && ($unsigned(gx) > thresh_q)) ? '1 : '0;
         2'd1: res = (!gy[SW-1] && ($unsigned(gy) > thresh_q)) ? '1 : '0;
         2'd2: res = (mag > {1'b0, thresh_q}) ? '1 : '0;
         default: res = (mag > (SW+1)'(2**PIX_W-1)) ? '1 : mag[PIX_W-1:0];
      endcase
   end

   // Line buffers and window are plain storage; the fill phase hides stale data.
   always_ff @(posedge clk) begin
      if (acc) begin
         lb0[in_x] <= lb1[in_x];
         lb1[in_x] <= in_pixel;
         win       <= nw;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         mode_q    <= '0;
         thresh_q  <= '0;
         last_q    <= 1'b0;
         in_x      <= '0;
         in_y      <= '0;
         oc_x      <= '0;
         oc_y      <= '0;
         oc_addr   <= '0;
         out_pixel <= '0;
         out_addr  <= '0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else if (start) begin
         state     <= RUN;
         mode_q    <= mode;
         thresh_q  <= thresh;
         last_q    <= 1'b0;
         in_x      <= '0;
         in_y      <= '0;
         oc_x      <= '0;
         oc_y      <= '0;
         oc_addr   <= '0;
         out_valid <= 1'b0;
         busy      <= 1'b1;
         done      <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         done      <= last_q;
         last_q    <= 1'b0;
         if (last_q)
            busy <= 1'b0;
         case (state)
            RUN: if (acc) begin
               if (in_x == XW'(IMG_W-1)) begin
                  in_x <= '0;
                  in_y <= in_y + 1'b1;
               end else begin
                  in_x <= in_x + 1'b1;
               end
               if (emit) begin
                  out_valid <= 1'b1;
                  out_addr  <= oc_addr;
                  out_pixel <= border ? '0 : res;
                  oc_addr   <= oc_addr + 1'b1;
                  if (oc_x == XW'(IMG_W-1)) begin
                     oc_x <= '0;
                     oc_y <= oc_y + 1'b1;
                  end else begin
                     oc_x <= oc_x + 1'b1;
                  end
               end
               if (last_in)
                  state <= FLUSH;
            end
            FLUSH: begin
               // Remaining addresses are the last row plus one edge pixel: all border.
               out_valid <= 1'b1;
               out_addr  <= oc_addr;
               out_pixel <= '0;
               oc_addr   <= oc_addr + 1'b1;
               if (oc_addr == ADDR_W'(N-1)) begin
                  state  <= IDLE;
                  last_q <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sobel_stream.sv
// Scoreboard bench for sobel_stream on an 8x6 frame: stimulus pushes expected
// (address, pixel) pairs, a negedge monitor pops and compares every output.
module tb_sobel_stream;
   localparam int W  = 8;
   localparam int H  = 6;
   localparam int P  = 4;
   localparam int N  = W*H;
   localparam int AW = $clog2(N);

   logic          clk = 1'b0;
   logic          rst_n, start, in_valid, in_ready, out_valid, busy, done;
   logic [1:0]    mode;
   logic [P+3:0]  thresh;
   logic [P-1:0]  in_pixel, out_pixel;
   logic [AW-1:0] out_addr;

   int checks = 0, failures = 0, done_cnt = 0, frames = 0;
   int img [N];
   int exp_pix [N];
   int sb_addr [$];
   int sb_pix [$];

   sobel_stream #(.IMG_W(W), .IMG_H(H), .PIX_W(P), .ADDR_W(AW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .thresh(thresh),
      .in_pixel(in_pixel), .in_valid(in_valid), .in_ready(in_ready),
      .out_pixel(out_pixel), .out_addr(out_addr), .out_valid(out_valid),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (done === 1'b1) done_cnt++;
         if (out_valid === 1'b1) begin
            if (sb_addr.size() == 0) chk("unexpected_output", 32'(out_addr), 32'hFFFF_FFFF);
            else begin
               chk("out_addr", 32'(out_addr), sb_addr.pop_front());
               chk("out_pixel", 32'(out_pixel), sb_pix.pop_front());
            end
         end
      end
   end

   function automatic int model(int x, int y, int md, int th);
      int w [3][3];
      int gx, gy, mag;
      if (x == 0 || x == W-1 || y == 0 || y == H-1) return 0;
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++)
            w[r][c] = img[(y-1+r)*W + x-1+c];
      gx  = (w[0][2] + 2*w[1][2] + w[2][2]) - (w[0][0] + 2*w[1][0] + w[2][0]);
      gy  = (w[2][0] + 2*w[2][1] + w[2][2]) - (w[0][0] + 2*w[0][1] + w[0][2]);
      mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
      case (md)
         0: return (gx > th) ? 15 : 0;
         1: return (gy > th) ? 15 : 0;
         2: return (mag > th) ? 15 : 0;
         default: return (mag > 15) ? 15 : mag;
      endcase
   endfunction

   // Hand-derived answer for the step images: only interior cols 3 and 4 light up.
   task automatic exp_step(input bit lit);
      for (int a = 0; a < N; a++)
         exp_pix[a] = (lit && (a%W == 3 || a%W == 4) && a/W >= 1 && a/W <= 4) ? 15 : 0;
   endtask

   task automatic fill_step(input bit inv);
      for (int a = 0; a < N; a++)
         img[a] = ((a%W >= 4) ^ inv) ? 15 : 0;
   endtask

   task automatic run_frame(input int md, input int th, input bit gaps, input int stop_at,
                            input bit chk_time);
      time t0;
      bit  ok, seen;
      int  high_cnt;
      @(posedge clk); #1;
      start = 1'b1; mode = 2'(md); thresh = 8'(th); t0 = $time;
      @(posedge clk); #1;
      start = 1'b0; mode = 2'($urandom); thresh = 8'($urandom);
      for (int k = 0; k < stop_at; k++) begin
         if (gaps)
            while ($urandom_range(0, 1) == 1) begin
               in_valid = 1'b0;
               @(posedge clk); #1;
            end
         in_valid = 1'b1; in_pixel = 4'(img[k]); ok = 1'b0;
         for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge clk); ok = in_ready;
            @(posedge clk); #1;
         end
         if (!ok) begin
            chk("accept_timeout", 32'(ok), 1);
            break;
         end
         if (k >= W+1) begin
            sb_addr.push_back(k-W-1);
            sb_pix.push_back(exp_pix[k-W-1]);
         end
      end
      in_valid = 1'b0;
      if (stop_at < N) return;
      for (int a = N-W-1; a < N; a++) begin
         sb_addr.push_back(a);
         sb_pix.push_back(exp_pix[a]);
      end
      seen = 1'b0; high_cnt = 0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (done) begin seen = 1'b1; break; end
         if (in_ready) high_cnt++;
      end
      frames++;
      chk("done_seen", 32'(seen), 1);
      chk("in_ready_during_flush", high_cnt, 0);
      if (chk_time) chk("start_to_done_cycles", 32'(($time - t0) / 10), 59);
      chk("busy_at_done", 32'(busy), 0);
      chk("scoreboard_drained", sb_addr.size(), 0);
      @(negedge clk);
      chk("done_width", 32'(done), 0);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_pixel = '0; mode = '0; thresh = '0;
      #12;
      chk("rst_in_ready", 32'(in_ready), 0);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_pixel", 32'(out_pixel), 0);
      chk("rst_out_addr", 32'(out_addr), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      rst_n = 1'b1;

      // uniform 7: no gradient anywhere, plus frame timing
      for (int a = 0; a < N; a++) begin img[a] = 7; exp_pix[a] = 0; end
      run_frame(2, 8, 1'b0, N, 1'b1);

      fill_step(1'b0);
      exp_step(1'b1); run_frame(0, 8, 1'b0, N, 1'b1);
      exp_step(1'b0); run_frame(1, 8, 1'b0, N, 1'b0);
      exp_step(1'b1); run_frame(2, 8, 1'b0, N, 1'b0);

      fill_step(1'b1);
      exp_step(1'b0); run_frame(0, 8, 1'b0, N, 1'b0);
      exp_step(1'b1); run_frame(3, 0, 1'b0, N, 1'b0);

      fill_step(1'b0);
      exp_step(1'b1); run_frame(0, 8, 1'b1, N, 1'b0);

      // abort mid-frame: partial outputs still precede the restart, no done for it
      for (int a = 0; a < N; a++) begin img[a] = 7; exp_pix[a] = 0; end
      run_frame(2, 8, 1'b0, 20, 1'b0);
      fill_step(1'b0); exp_step(1'b1);
      run_frame(0, 8, 1'b0, N, 1'b1);
      chk("done_pulses_after_abort", done_cnt, frames);

      // asynchronous reset while an output is on the bus
      run_frame(0, 8, 1'b0, 15, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_out_valid", 32'(out_valid), 0);
      chk("async_rst_out_pixel", 32'(out_pixel), 0);
      chk("async_rst_out_addr", 32'(out_addr), 0);
      chk("async_rst_busy", 32'(busy), 0);
      chk("async_rst_in_ready", 32'(in_ready), 0);
      sb_addr.delete(); sb_pix.delete();
      #23 rst_n = 1'b1;
      run_frame(0, 8, 1'b0, N, 1'b1);

      // noisy image against the reference model, every mode
      for (int a = 0; a < N; a++) begin
         img[a] = $urandom_range(0, 5) + $urandom_range(0, 5) + $urandom_range(0, 5);
         if (img[a] > 15) img[a] = 15;
      end
      for (int md = 0; md < 4; md++) begin
         int th;
         th = $urandom_range(0, 60);
         for (int a = 0; a < N; a++) exp_pix[a] = model(a%W, a/W, md, th);
         run_frame(md, th, md[0], N, 1'b0);
      end

      chk("done_pulses_total", done_cnt, frames);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
